// File: rtl/expr_vector_driver.sv
// rtl/expr_vector_driver.sv - LFSR operand driver with MISR response signature
// Drives pseudo-random operands into an expression block one vector per cycle and compacts its responses.
module expr_vector_driver #(
   parameter int CNT_W = 16,
   parameter int SIG_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [CNT_W-1:0]        num_vec,
   input  logic [63:0]             seed,
   output logic [3:0]              a0,
   output logic [4:0]              a1,
   output logic [5:0]              a2,
   output logic signed [3:0]       a3,
   output logic signed [4:0]       a4,
   output logic signed [5:0]       a5,
   output logic [3:0]              b0,
   output logic [4:0]              b1,
   output logic [5:0]              b2,
   output logic signed [3:0]       b3,
   output logic signed [4:0]       b4,
   output logic signed [5:0]       b5,
   input  logic [89:0]             y,
   output logic                    busy,
   output logic                    done,
   output logic [SIG_W-1:0]        sig,
   output logic [CNT_W-1:0]        vec_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   logic [1:0]       r_state;
   logic [63:0]      r_lfsr;
   logic [SIG_W-1:0] r_sig;
   logic [CNT_W-1:0] r_vec_cnt;
   logic [CNT_W-1:0] r_num_vec;

   logic [63:0]      w_lfsr_next;
   logic [31:0]      w_fold;
   logic [SIG_W-1:0] w_sig_next;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_lfsr_next = {1'b0, r_lfsr[63:1]} ^ (r_lfsr[0] ? 64'hD800000000000000 : 64'h0);
   assign w_fold      = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
   assign w_sig_next  = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? 32'h04C11DB7 : 32'h0) ^ w_fold;
   assign w_cnt_inc   = r_vec_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_lfsr    <= 64'h1;
         r_sig     <= '0;
         r_vec_cnt <= '0;
         r_num_vec <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sig     <= 32'hFFFFFFFF;
                  r_vec_cnt <= '0;
                  if (num_vec != '0) begin
                     // An all-zero seed would lock the LFSR, so substitute 1.
                     r_lfsr    <= (seed == 64'h0) ? 64'h1 : seed;
                     r_num_vec <= num_vec;
                     r_state   <= S_RUN;
                  end else begin
                     r_state   <= S_FIN;
                  end
               end
            end
            S_RUN: begin
               r_sig     <= w_sig_next;
               r_lfsr    <= w_lfsr_next;
               r_vec_cnt <= w_cnt_inc;
               if (w_cnt_inc == r_num_vec) r_state <= S_FIN;
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Operands are live only while running so the block under test sees quiet zeros otherwise.
   always_comb begin
      a0 = '0; a1 = '0; a2 = '0; a3 = '0; a4 = '0; a5 = '0;
      b0 = '0; b1 = '0; b2 = '0; b3 = '0; b4 = '0; b5 = '0;
      if (r_state == S_RUN) begin
         a0 = r_lfsr[3:0];
         a1 = r_lfsr[8:4];
         a2 = r_lfsr[14:9];
         a3 = r_lfsr[18:15];
         a4 = r_lfsr[23:19];
         a5 = r_lfsr[29:24];
         b0 = r_lfsr[33:30];
         b1 = r_lfsr[38:34];
         b2 = r_lfsr[44:39];
         b3 = r_lfsr[48:45];
         b4 = r_lfsr[53:49];
         b5 = r_lfsr[59:54];
      end
   end

   assign busy    = (r_state == S_RUN);
   assign done    = (r_state == S_FIN);
   assign sig     = r_sig;
   assign vec_cnt = r_vec_cnt;

endmodule

// File: tb/tb_expr_vector_driver.sv
// tb/tb_expr_vector_driver.sv - directed self-checking bench for expr_vector_driver
// A reference LFSR/MISR model supplies expected operands and signatures.
module tb_expr_vector_driver;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [15:0]        num_vec;
   logic [63:0]        seed;
   logic [3:0]         a0;
   logic [4:0]         a1;
   logic [5:0]         a2;
   logic signed [3:0]  a3;
   logic signed [4:0]  a4;
   logic signed [5:0]  a5;
   logic [3:0]         b0;
   logic [4:0]         b1;
   logic [5:0]         b2;
   logic signed [3:0]  b3;
   logic signed [4:0]  b4;
   logic signed [5:0]  b5;
   logic [89:0]        y;
   logic               busy;
   logic               done;
   logic [31:0]        sig;
   logic [15:0]        vec_cnt;

   int checks = 0;
   int errors = 0;
   int y_mode = 0;

   logic [59:0] ops;

   expr_vector_driver #(.CNT_W(16), .SIG_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .num_vec(num_vec), .seed(seed),
      .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5),
      .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5),
      .y(y), .busy(busy), .done(done), .sig(sig), .vec_cnt(vec_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [89:0] y_from_ops(int mode, logic [59:0] o);
      logic [29:0] mix;
      mix = 30'(o[14:9] * o[44:39]) + 30'(o[8:4]) + {o[59:54], 24'h0};
      case (mode)
         0:       return 90'h0;
         1:       return {90{1'b1}};
         default: return {o, mix};
      endcase
   endfunction

   assign ops = {b5, b4, b3, b2, b1, b0, a5, a4, a3, a2, a1, a0};
   always_comb y = y_from_ops(y_mode, ops);

   function automatic logic [63:0] lfsr_step(logic [63:0] l);
      return {1'b0, l[63:1]} ^ (l[0] ? 64'hD800000000000000 : 64'h0);
   endfunction

   function automatic logic [31:0] misr_step(logic [31:0] s, logic [89:0] yy);
      logic [31:0] f;
      f = yy[31:0] ^ yy[63:32] ^ {6'b0, yy[89:64]};
      return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
   endfunction

   function automatic logic [31:0] model_sig(logic [63:0] sd, int n, int mode);
      logic [63:0] l;
      logic [31:0] s;
      l = (sd == 64'h0) ? 64'h1 : sd;
      s = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         s = misr_step(s, y_from_ops(mode, l[59:0]));
         l = lfsr_step(l);
      end
      return s;
   endfunction

   // Pulses start, then steps until done; optional re-pulse or reset after a number of busy cycles.
   task automatic run(input logic [15:0] n, input logic [63:0] sd, input int repulse_at,
                      input int reset_at, output int busy_n, output bit got_done, output bit timed_out);
      busy_n = 0; got_done = 0; timed_out = 1;
      @(negedge clk);
      start = 1'b1; num_vec = n; seed = sd;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (done) begin got_done = 1; timed_out = 0; break; end
         if (busy) busy_n++;
         if (reset_at > 0 && busy_n == reset_at) begin
            reset = 1'b1; timed_out = 0;
            @(posedge clk);
            @(negedge clk);
            break;
         end
         if (repulse_at > 0 && busy_n == repulse_at) begin
            start = 1'b1; num_vec = 16'd5; seed = 64'hDEADBEEFCAFEF00D;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; num_vec = '0; seed = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++; $display("FAIL reset_flags: got busy/done %b, expected 00", {busy, done});
      end
      checks++;
      if (sig !== 32'h0 || vec_cnt !== 16'h0) begin
         errors++; $display("FAIL reset_regs: got sig %h cnt %0d, expected 0 0", sig, vec_cnt);
      end
      checks++;
      if (ops !== 60'h0) begin
         errors++; $display("FAIL reset_ops: got %h, expected 0", ops);
      end
      reset = 1'b0;
   endtask

   task automatic test_single(input logic [63:0] sd, input int mode, input logic [31:0] exp_sig, input string nm);
      y_mode = mode;
      @(negedge clk);
      start = 1'b1; num_vec = 16'd1; seed = sd;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || ops !== 60'h1) begin
         errors++; $display("FAIL %s_run: got busy %b ops %h, expected 1 %h", nm, busy, ops, 60'h1);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || ops !== 60'h0) begin
         errors++; $display("FAIL %s_fin: got done %b busy %b ops %h, expected 1 0 0", nm, done, busy, ops);
      end
      checks++;
      if (sig !== exp_sig || vec_cnt !== 16'd1) begin
         errors++; $display("FAIL %s_sig: got %h cnt %0d, expected %h 1", nm, sig, vec_cnt, exp_sig);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || sig !== exp_sig) begin
         errors++; $display("FAIL %s_idle: got done %b sig %h, expected 0 %h", nm, done, sig, exp_sig);
      end
   endtask

   task automatic test_zero_vec;
      y_mode = 2;
      @(negedge clk);
      start = 1'b1; num_vec = 16'd0; seed = 64'h55;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || ops !== 60'h0) begin
         errors++; $display("FAIL zero_vec_fin: got done %b busy %b ops %h, expected 1 0 0", done, busy, ops);
      end
      checks++;
      if (sig !== 32'hFFFFFFFF || vec_cnt !== 16'd0) begin
         errors++; $display("FAIL zero_vec_sig: got %h cnt %0d, expected ffffffff 0", sig, vec_cnt);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL zero_vec_idle: got done %b busy %b, expected 0 0", done, busy);
      end
   endtask

   task automatic test_slices;
      logic [63:0] l;
      l = 64'h0123456789ABCDEF;
      y_mode = 2;
      @(negedge clk);
      start = 1'b1; num_vec = 16'd3; seed = l;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy !== 1'b1 || ops !== l[59:0]) begin
            errors++; $display("FAIL slices_%0d: got busy %b ops %h, expected 1 %h", i, busy, ops, l[59:0]);
         end
         l = lfsr_step(l);
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || sig !== model_sig(64'h0123456789ABCDEF, 3, 2)) begin
         errors++; $display("FAIL slices_sig: got done %b sig %h, expected 1 %h", done, sig,
                            model_sig(64'h0123456789ABCDEF, 3, 2));
      end
   endtask

   task automatic test_restart_ignored;
      int bn; bit gd, to;
      logic [31:0] exp_sig;
      y_mode = 2;
      exp_sig = model_sig(64'h1234_5678_9ABC_DEF1, 100, 2);
      run(16'd100, 64'h1234_5678_9ABC_DEF1, 10, 0, bn, gd, to);
      checks++;
      if (to || !gd) begin
         errors++; $display("FAIL restart_done: got done %b timeout %b, expected 1 0", gd, to);
      end
      checks++;
      if (bn !== 100 || vec_cnt !== 16'd100) begin
         errors++; $display("FAIL restart_len: got busy %0d cnt %0d, expected 100 100", bn, vec_cnt);
      end
      checks++;
      if (sig !== exp_sig) begin
         errors++; $display("FAIL restart_sig: got %h, expected %h", sig, exp_sig);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run;
      int bn; bit gd, to;
      bit saw_done;
      logic [31:0] exp_sig;
      y_mode = 2;
      exp_sig = model_sig(64'hA5A5_0F0F_3C3C_9669, 120, 2);
      run(16'd120, 64'hA5A5_0F0F_3C3C_9669, 0, 50, bn, gd, to);
      checks++;
      if (gd || busy !== 1'b0 || done !== 1'b0 || ops !== 60'h0) begin
         errors++; $display("FAIL midreset_state: got early_done %b busy %b done %b ops %h, expected 0 0 0 0",
                            gd, busy, done, ops);
      end
      checks++;
      if (sig !== 32'h0 || vec_cnt !== 16'h0) begin
         errors++; $display("FAIL midreset_regs: got sig %h cnt %0d, expected 0 0", sig, vec_cnt);
      end
      reset = 1'b0;
      saw_done = 0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         if (done || busy) saw_done = 1;
      end
      checks++;
      if (saw_done) begin
         errors++; $display("FAIL midreset_quiet: got activity 1, expected 0");
      end
      run(16'd120, 64'hA5A5_0F0F_3C3C_9669, 0, 0, bn, gd, to);
      checks++;
      if (!gd || bn !== 120 || sig !== exp_sig) begin
         errors++; $display("FAIL midreset_rerun: got done %b busy %0d sig %h, expected 1 120 %h", gd, bn, sig, exp_sig);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single(64'h1, 0, 32'hFB3EE249, "y_zero");
      test_single(64'h1, 1, 32'hF8C11DB6, "y_ones");
      test_single(64'h0, 0, 32'hFB3EE249, "seed_zero");
      test_zero_vec();
      test_slices();
      test_restart_ignored();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/expr_vector_driver.md
EXPR_VECTOR_DRIVER -- requirements
Module: expr_vector_driver

Interface
REQ-001 Parameter CNT_W, default 16, width of vector-count request and progress counter.
REQ-002 Parameter SIG_W, fixed 32, signature width; other values are not supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 num_vec  input  CNT_W  vectors to apply; latched on accepted start.
REQ-007 seed  input  64  LFSR seed; latched on accepted start.
REQ-008 a0,a1,a2  output  4,5,6  unsigned operand drive.
REQ-009 a3,a4,a5  output  4,5,6  signed operand drive.
REQ-010 b0,b1,b2  output  4,5,6  unsigned operand drive.
REQ-011 b3,b4,b5  output  4,5,6  signed operand drive.
REQ-012 y  input  90  packed response from the expression block under test, combinational from a*/b*.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 sig  output  32  response signature (MISR).
REQ-016 vec_cnt  output  CNT_W  vectors applied in current/last run.

Function
REQ-017 FSM states SHALL be IDLE, RUN, FIN; reset state IDLE.
REQ-018 IDLE + start + num_vec!=0 SHALL load lfsr=seed (seed==0 replaced by 64'h1), sig=32'hFFFFFFFF, vec_cnt=0, latch num_vec, go RUN.
REQ-019 IDLE + start + num_vec==0 SHALL load sig=32'hFFFFFFFF, vec_cnt=0, go FIN directly.
REQ-020 In RUN, operand outputs SHALL be combinational slices of lfsr: a0=[3:0], a1=[8:4], a2=[14:9], a3=[18:15], a4=[23:19], a5=[29:24], b0=[33:30], b1=[38:34], b2=[44:39], b3=[48:45], b4=[53:49], b5=[59:54].
REQ-021 Outside RUN, all operand outputs SHALL be zero.
REQ-022 Each RUN cycle SHALL fold the current y into sig, advance lfsr once, increment vec_cnt: one vector per cycle, response sampled same cycle it is driven.
REQ-023 LFSR SHALL be Galois right-shift: next = {1'b0,lfsr[63:1]} ^ (lfsr[0] ? 64'hD800000000000000 : 0).
REQ-024 MISR: fold = y[31:0] ^ y[63:32] ^ {6'b0,y[89:64]}; next sig = {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.
REQ-025 RUN SHALL exit to FIN on the edge where vec_cnt becomes equal to latched num_vec; exactly num_vec vectors applied.
REQ-026 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 sig and vec_cnt SHALL hold their final values in FIN and IDLE until the next accepted start.
REQ-028 start while in RUN or FIN SHALL be ignored; changes to num_vec/seed after acceptance SHALL have no effect.
REQ-029 vec_cnt SHALL not wrap: maximum run is 2^CNT_W-1 vectors.

Reset
REQ-030 reset SHALL win over all other inputs, including mid-run, and SHALL force IDLE, busy=0, done=0, sig=0, vec_cnt=0, lfsr=64'h1, operands=0 on the next edge.
REQ-031 After reset deassertion, the block SHALL accept start on the first IDLE cycle.

Verification
REQ-032 seed=1, num_vec=1, y=0 -> one RUN cycle with a0=4'h1, all other operands 0; done one cycle later; sig=32'hFB3EE249, vec_cnt=1.
REQ-033 Same as REQ-032 with y=90'h3FF...F (all ones) -> sig=32'hF8C11DB6.
REQ-034 seed=0, num_vec=1, y=0 -> behaviour identical to REQ-032.
REQ-035 num_vec=0 -> busy never high, done one cycle after start, sig=32'hFFFFFFFF, vec_cnt=0, operands stay 0.
REQ-036 num_vec=100, start re-pulsed at cycle 10 with num_vec=5 -> run unaffected, busy high exactly 100 cycles, vec_cnt=100.
REQ-037 reset asserted mid-run at vector 50 -> next edge: IDLE, busy=0, sig=0, vec_cnt=0, no done pulse; a fresh start reproduces the reference-model signature.
